// File: rtl/tc_prog_delay_line.sv
// Programmable-latency alignment pipe: negedge capture followed by a MAX_DEPTH-stage posedge chain.
// Output tap chosen at runtime (1..MAX_DEPTH cycles); supports stall, flush and occupancy tracking.
module tc_prog_delay_line #(
  parameter int BIT_WIDTH = 8,
  parameter int MAX_DEPTH = 8,
  parameter int SEL_WIDTH = 3,
  parameter int CNT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 flush,
  input  logic [SEL_WIDTH-1:0] depth_sel,
  input  logic [BIT_WIDTH-1:0] in,
  input  logic                 in_valid,
  output logic [BIT_WIDTH-1:0] out,
  output logic                 out_valid,
  output logic                 sel_clamped,
  output logic [CNT_WIDTH-1:0] occupancy,
  output logic                 empty
);

  localparam int LAST = MAX_DEPTH - 1;

  logic                 rst_seen;
  logic [BIT_WIDTH-1:0] cap_data;
  logic                 cap_valid;
  logic [BIT_WIDTH-1:0] stage_data  [MAX_DEPTH];
  logic                 stage_valid [MAX_DEPTH];
  logic [CNT_WIDTH-1:0] occ_inc;
  logic [CNT_WIDTH-1:0] occ_dec;
  int                   tap;

  always_ff @(posedge clk) begin
    rst_seen <= rst;
  end

  // Half-cycle capture: a reset posedge forces the following negedge to sample 0/invalid.
  always_ff @(negedge clk) begin
    if (rst_seen) begin
      cap_data  <= '0;
      cap_valid <= 1'b0;
    end else begin
      cap_data  <= in;
      cap_valid <= in_valid;
    end
  end

  assign occ_inc = CNT_WIDTH'(cap_valid);
  assign occ_dec = CNT_WIDTH'(stage_valid[LAST]);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < MAX_DEPTH; i++) begin
        stage_data[i]  <= '0;
        stage_valid[i] <= 1'b0;
      end
      occupancy <= '0;
    end else if (en) begin
      stage_data[0]  <= cap_data;
      stage_valid[0] <= cap_valid;
      for (int i = 1; i < MAX_DEPTH; i++) begin
        stage_data[i]  <= stage_data[i-1];
        stage_valid[i] <= stage_valid[i-1];
      end
      occupancy <= occupancy + occ_inc - occ_dec;
    end
  end

  assign sel_clamped = int'(depth_sel) > LAST;
  assign tap         = sel_clamped ? LAST : int'(depth_sel);

  // Tap switches take effect immediately; no realignment of the stream.
  always_comb begin
    out       = stage_data[0];
    out_valid = stage_valid[0];
    for (int i = 1; i < MAX_DEPTH; i++) begin
      if (i == tap) begin
        out       = stage_data[i];
        out_valid = stage_valid[i];
      end
    end
  end

  assign empty = (occupancy == '0);

endmodule

// File: doc/tc_prog_delay_line.md
Name: tc_prog_delay_line

Overview:
- Parametrised, multi-stage successor to the single-cycle delay line.
- Captures a data word and a valid tag on the falling edge of clk, then shifts them through a MAX_DEPTH-deep chain on the rising edge.
- Output comes from a runtime-selectable tap, so delay is 1..MAX_DEPTH cycles.
- Adds stall (en), flush, depth clamping and an in-flight occupancy counter.
- Used wherever the circuit needs a programmable-latency alignment pipe between components.

Parameters:
- BIT_WIDTH, 8, data width in bits.
- MAX_DEPTH, 8, number of chain stages; legal range 1..256.
- SEL_WIDTH, 3, width of depth_sel; must satisfy 2^SEL_WIDTH >= MAX_DEPTH.
- CNT_WIDTH, 4, width of occupancy; must hold the value MAX_DEPTH.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  chain advance enable; 0 = hold all stages.
- flush  in  1  synchronous clear of chain contents.
- depth_sel  in  SEL_WIDTH  selected delay minus one (0 = 1 cycle).
- in  in  BIT_WIDTH  data input.
- in_valid  in  1  valid tag for in.
- out  out  BIT_WIDTH  data at the selected tap.
- out_valid  out  1  valid tag at the selected tap.
- sel_clamped  out  1  high when depth_sel+1 > MAX_DEPTH.
- occupancy  out  CNT_WIDTH  number of valid entries in the whole chain.
- empty  out  1  occupancy == 0.

Behaviour:
- Capture stage, on negedge clk:
  - cap_data <= in and cap_valid <= in_valid.
  - If rst_seen is set, cap_data and cap_valid load 0 instead.
  - rst_seen is a flag registered from rst at each posedge.
  - The capture stage ignores en and flush.
- Chain, on posedge clk, priority rst > flush > en:
  - rst: all stage data and valid bits cleared to 0; occupancy <= 0; rst_seen <= 1.
  - flush: all stage data and valid bits cleared to 0; occupancy <= 0. The sample in the capture stage is discarded and does not enter the chain.
  - en: stage[0] <= cap; stage[i] <= stage[i-1] for i = 1..MAX_DEPTH-1. The entry in stage[MAX_DEPTH-1] is dropped.
  - Otherwise all stages hold.
  - rst_seen <= rst on every posedge.
- Tap selection, combinational from the stage registers:
  - eff = min(depth_sel, MAX_DEPTH-1).
  - out = stage[eff].data; out_valid = stage[eff].valid.
  - sel_clamped = (depth_sel > MAX_DEPTH-1).
- Latency: with en held at 1, a word present around negedge of cycle n appears on out during cycle n+eff+1. With eff = 0 this is identical to the legacy one-cycle delay line.
- Changing depth_sel mid-stream:
  - Takes effect in the same cycle, with no realignment.
  - Words may be skipped (depth decreased) or repeated (depth increased). This is intended.
- Occupancy, on each posedge with en = 1 and no rst or flush:
  - occupancy <= occupancy + cap_valid − stage[MAX_DEPTH-1].valid.
  - Never exceeds MAX_DEPTH and never underflows.
  - Holds when en = 0.
- Reset and empty values:
  - After reset: out = 0, out_valid = 0, occupancy = 0, empty = 1.
  - sel_clamped is purely combinational.
- Reset mid-operation:
  - In-flight data is lost.
  - The first negedge after a reset posedge captures 0/invalid.
  - Normal capture resumes at the negedge following the first posedge with rst = 0.
- Boundary cases:
  - MAX_DEPTH = 1: depth_sel is ignored except for sel_clamped.
  - flush and en together: flush wins.
  - en = 0 with in_valid = 1: the input is overwritten at the next negedge and lost. No backpressure is provided.

Test Plan:
- Reset then idle:
  - Stimulus: rst high for 2 cycles, then low, in = 0xFF, in_valid = 0.
  - Required: out = 0x00 and out_valid = 0 during reset; occupancy = 0 and empty = 1; in the first post-reset cycle, out stays 0.
- Fixed depth:
  - Stimulus: MAX_DEPTH = 8, depth_sel = 3, en = 1, in = 0x01, 0x02, 0x03… each valid.
  - Required: 0x01 appears on out exactly 4 cycles after being presented; the sequence is preserved; occupancy climbs 1..8 then stays at 8.
- Stall:
  - Stimulus: depth_sel = 0; stream 0xA0..0xA5; en low for cycles 3–4.
  - Required: out holds 0xA2 for the stall cycles; samples presented while en is low are lost; occupancy is constant during the stall.
- Flush versus en:
  - Stimulus: chain full (occupancy = 8); assert flush and en in the same cycle.
  - Required: next cycle out_valid = 0, occupancy = 0, empty = 1; the captured word is absent afterwards.
- Clamp and tap switch:
  - Stimulus: MAX_DEPTH = 6, depth_sel = 7.
  - Required: sel_clamped = 1 and out = stage[5]; switching depth_sel 5→1 mid-stream changes out in the same cycle to the word 2 cycles old.
- Reset mid-stream:
  - Stimulus: rst pulsed for one cycle during a valid stream.
  - Required: all valids clear; the first post-reset negedge captures 0; valid data resumes one cycle later; occupancy counts from 0.
